scan_loader: RTL and testbench

- Serial programmer for the configuration scan chain: accepts a parallel CHAIN_LEN-bit word on a valid/ready handshake and shifts it MSB-first into the chain via scan_en/scan_in.
- Simultaneously captures the bits leaving the chain on scan_out, so the previous chain contents come back as rd_data for readback and verification.
- Sits between the host/config bus and the scan_rom chain(s). It is the driving end of the chain protocol.

---
 rtl/scan_loader.sv | 132 +++++++++++++
 tb/tb_scan_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/scan_loader.sv
// Scan-chain programmer: shifts a parallel word MSB-first into the configuration
// chain and captures the displaced chain contents for readback.
module scan_loader #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned CLK_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CHAIN_LEN-1:0] cfg_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rd_data
);

  localparam int unsigned BIT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned SLOT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CLK_DIV - 1);
  localparam logic              EN_AT_START = (CLK_DIV == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [SLOT_W-1:0]    slot_cnt, slot_cnt_nxt, slot_inc;
  logic [CHAIN_LEN-1:0] shift_buf, shift_buf_nxt;
  logic [CHAIN_LEN-1:0] rd_shift, rd_shift_nxt;
  logic [CHAIN_LEN-1:0] rd_data_nxt;
  logic scan_en_nxt, scan_in_nxt, busy_nxt, done_nxt, cfg_ready_nxt;
  logic accept, last_slot, last_bit;

  assign accept    = cfg_valid & cfg_ready;
  assign last_slot = (slot_cnt == LAST_SLOT);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign slot_inc  = slot_cnt + SLOT_W'(1);

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      slot_cnt  <= '0;
      shift_buf <= '0;
      rd_shift  <= '0;
      rd_data   <= '0;
      scan_en   <= 1'b0;
      scan_in   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      slot_cnt  <= slot_cnt_nxt;
      shift_buf <= shift_buf_nxt;
      rd_shift  <= rd_shift_nxt;
      rd_data   <= rd_data_nxt;
      scan_en   <= scan_en_nxt;
      scan_in   <= scan_in_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cfg_ready <= cfg_ready_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? SHIFT : IDLE;
      SHIFT:      if (last_slot && last_bit) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Next values of counters, buffers and outputs
  always_comb begin
    bit_cnt_nxt   = bit_cnt;
    slot_cnt_nxt  = slot_cnt;
    shift_buf_nxt = shift_buf;
    rd_data_nxt   = rd_data;
    scan_en_nxt   = 1'b0;
    scan_in_nxt   = 1'b0;
    done_nxt      = 1'b0;
    busy_nxt      = (state_nxt == SHIFT);
    cfg_ready_nxt = (state_nxt != SHIFT);
    // Capture the pre-shift chain MSB on every shift edge
    rd_shift_nxt  = scan_en ? {rd_shift[CHAIN_LEN-2:0], scan_out} : rd_shift;

    case (state)
      IDLE, DONE: begin
        if (accept) begin
          bit_cnt_nxt   = '0;
          slot_cnt_nxt  = '0;
          shift_buf_nxt = {cfg_data[CHAIN_LEN-2:0], 1'b0};
          scan_in_nxt   = cfg_data[CHAIN_LEN-1];
          scan_en_nxt   = EN_AT_START;
        end
      end
      SHIFT: begin
        if (last_slot) begin
          slot_cnt_nxt = '0;
          if (last_bit) begin
            done_nxt    = 1'b1;
            rd_data_nxt = rd_shift_nxt;
          end else begin
            bit_cnt_nxt   = bit_cnt + BIT_W'(1);
            shift_buf_nxt = {shift_buf[CHAIN_LEN-2:0], 1'b0};
            scan_in_nxt   = shift_buf[CHAIN_LEN-1];
            scan_en_nxt   = EN_AT_START;
          end
        end else begin
          slot_cnt_nxt = slot_inc;
          scan_in_nxt  = scan_in;
          scan_en_nxt  = (slot_inc == LAST_SLOT);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader with behavioural 8-bit scan chains on a
// CLK_DIV=1 instance and a CLK_DIV=3 instance.
module tb_scan_loader;

  logic clk = 1'b0;
  logic reset;
  logic chain_rst;

  logic       cfg_valid1, cfg_ready1, scan_en1, scan_in1, scan_out1, busy1, done1;
  logic [7:0] cfg_data1, rd_data1, chain1;
  logic       cfg_valid3, cfg_ready3, scan_en3, scan_in3, scan_out3, busy3, done3;
  logic [7:0] cfg_data3, rd_data3, chain3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  scan_loader #(.CHAIN_LEN(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
    .cfg_data(cfg_data1), .scan_en(scan_en1), .scan_in(scan_in1),
    .scan_out(scan_out1), .busy(busy1), .done(done1), .rd_data(rd_data1)
  );

  scan_loader #(.CHAIN_LEN(8), .CLK_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_data(cfg_data3), .scan_en(scan_en3), .scan_in(scan_in3),
    .scan_out(scan_out3), .busy(busy3), .done(done3), .rd_data(rd_data3)
  );

  // Chain models: shift in at LSB, serial out from MSB
  always @(posedge clk) begin
    if (chain_rst) begin
      chain1 <= 8'h00;
      chain3 <= 8'h00;
    end else begin
      if (scan_en1) chain1 <= {chain1[6:0], scan_in1};
      if (scan_en3) chain3 <= {chain3[6:0], scan_in3};
    end
  end
  assign scan_out1 = chain1[7];
  assign scan_out3 = chain3[7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full load on the CLK_DIV=1 instance, checked shift by shift
  task automatic load1(input string nm, input logic [7:0] w, input logic [7:0] exp_rd,
                       input bit noisy);
    logic [7:0] seq;
    int         en_cnt;
    int         waited;
    waited = 0;
    while (!cfg_ready1 && waited < 20) begin
      step();
      waited++;
    end
    if (waited >= 20) check({nm, "_ready_timeout"}, 32'(cfg_ready1), 32'd1);
    cfg_valid1 = 1'b1;
    cfg_data1  = w;
    step();
    cfg_valid1 = 1'b0;
    check({nm, "_accept_busy"}, 32'(busy1), 32'd1);
    seq    = 8'h00;
    en_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      seq = {seq[6:0], scan_in1};
      if (scan_en1) en_cnt++;
      if (noisy) begin
        cfg_valid1 = 1'b1;
        cfg_data1  = 8'($urandom());
      end
      step();
    end
    cfg_valid1 = 1'b0;
    check({nm, "_scan_in_seq"}, 32'(seq), 32'(w));
    check({nm, "_scan_en_cnt"}, 32'(en_cnt), 32'd8);
    check({nm, "_done"}, 32'(done1), 32'd1);
    check({nm, "_done_scan_en"}, 32'({scan_en1, scan_in1}), 32'd0);
    check({nm, "_rd_data"}, 32'(rd_data1), 32'(exp_rd));
    check({nm, "_chain"}, 32'(chain1), 32'(w));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] prev, w;
    int         en_cnt, pace_err, done_at;

    reset      = 1'b1;
    chain_rst  = 1'b1;
    cfg_valid1 = 1'b0;
    cfg_data1  = 8'h00;
    cfg_valid3 = 1'b0;
    cfg_data3  = 8'h00;
    step();
    step();
    check("rst_outputs", 32'({cfg_ready1, busy1, done1, scan_en1, scan_in1}), 32'd0);
    check("rst_rd_data", 32'(rd_data1), 32'd0);
    reset     = 1'b0;
    chain_rst = 1'b0;
    step();
    check("post_rst_ready", 32'({cfg_ready1, cfg_ready3}), 32'b11);

    load1("basic", 8'hA5, 8'h00, 1'b0);
    load1("readback", 8'h3C, 8'hA5, 1'b0);
    load1("noisy", 8'h5A, 8'h3C, 1'b1);
    check("b2b_in_done", 32'({done1, cfg_ready1}), 32'b11);
    load1("b2b", 8'h96, 8'h5A, 1'b0);

    // Reset on the 4th shift edge of a 0xF0 load
    cfg_valid1 = 1'b1;
    cfg_data1  = 8'hF0;
    step();
    cfg_valid1 = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("midrst_outputs", 32'({scan_en1, busy1, done1, cfg_ready1}), 32'd0);
    check("midrst_rd_data", 32'(rd_data1), 32'd0);
    reset = 1'b0;
    step();
    check("midrst_ready", 32'({cfg_ready1, done1}), 32'b10);
    check("midrst_chain", 32'(chain1), 32'h6F);
    load1("reload", 8'h81, 8'h6F, 1'b0);

    // Paced load on the CLK_DIV=3 instance
    cfg_valid3 = 1'b1;
    cfg_data3  = 8'hFF;
    step();
    cfg_valid3 = 1'b0;
    en_cnt   = 0;
    pace_err = 0;
    done_at  = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done3) begin
        done_at = c;
        break;
      end
      if (scan_en3) en_cnt++;
      if (scan_en3 !== (c % 3 == 0)) pace_err++;
      if (scan_in3 !== 1'b1) pace_err++;
      step();
    end
    check("pace_en_cnt", 32'(en_cnt), 32'd8);
    check("pace_slot_err", 32'(pace_err), 32'd0);
    check("pace_done_at", 32'(done_at), 32'd25);
    check("pace_done_scan", 32'({scan_en3, scan_in3}), 32'd0);
    check("pace_rd_data", 32'(rd_data3), 32'h00);
    check("pace_chain", 32'(chain3), 32'hFF);

    // Loopback through the chain: readback is always the previous word
    prev = 8'h81;
    for (int i = 0; i < 100; i++) begin
      w = 8'($urandom());
      load1("loop", w, prev, 1'b0);
      prev = w;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
